// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC and the IF/ID register,
//               with a one-entry skid buffer for words returned during stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buffer;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_id_instr;

    assign pc_out      = r_pc;
    // Request is masked while reset is applied so the reset cycle never fetches.
    assign imem_req    = (r_state == ST_FETCH) && !rst;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;
    assign id_instr    = r_id_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_buffer      <= 32'h0;
            r_id_valid    <= 1'b0;
            r_id_pc       <= 32'h0;
            r_id_pc_plus4 <= 32'h0;
            r_id_instr    <= NOP_INSTR;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        r_pc       <= redirect_pc;
                        r_id_valid <= 1'b0;
                        r_id_instr <= NOP_INSTR;
                    end else if (imem_ready && !stall) begin
                        r_id_pc       <= r_pc;
                        r_id_pc_plus4 <= npc_in;
                        r_id_instr    <= imem_rdata;
                        r_id_valid    <= 1'b1;
                        r_pc          <= npc_in;
                    end else if (imem_ready) begin
                        // Decode is stalled: park the word until it can move on.
                        r_buffer <= imem_rdata;
                        r_state  <= ST_HOLD;
                    end else if (!stall) begin
                        r_id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        r_pc       <= redirect_pc;
                        r_id_valid <= 1'b0;
                        r_id_instr <= NOP_INSTR;
                        r_buffer   <= 32'h0;
                        r_state    <= ST_FETCH;
                    end else if (!stall) begin
                        r_id_pc       <= r_pc;
                        r_id_pc_plus4 <= npc_in;
                        r_id_instr    <= r_buffer;
                        r_id_valid    <= 1'b1;
                        r_pc          <= npc_in;
                        r_state       <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Directed plus random checking of if_stage against a queue-based
//               model of the fetch pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    int total = 0;
    int bad   = 0;

    // Expected architectural view
    logic [31:0] m_pc;
    logic [31:0] skid[$];
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_ip4;
    logic [31:0] m_instr;

    if_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_out         (pc_out),
        .npc_in         (npc_in),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    // Next-PC adder stand-in
    assign npc_in = pc_out + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic deliver(input logic [31:0] word);
        m_ipc   = m_pc;
        m_ip4   = m_pc + 32'd4;
        m_instr = word;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic [31:0] rd,
                       input logic s, input logic rv, input logic [31:0] rp);
        rst            = r;
        imem_ready     = rdy;
        imem_rdata     = rd;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        @(posedge clk);
        if (r) begin
            m_pc    = C_RESET_PC;
            skid.delete();
            m_valid = 1'b0;
            m_ipc   = 32'h0;
            m_ip4   = 32'h0;
            m_instr = C_NOP;
        end else if (rv) begin
            m_pc    = rp;
            m_valid = 1'b0;
            m_instr = C_NOP;
            skid.delete();
        end else if (skid.size() != 0) begin
            if (!s) deliver(skid.pop_front());
        end else if (rdy) begin
            if (s) skid.push_back(rd);
            else   deliver(rd);
        end else if (!s) begin
            m_valid = 1'b0;
        end
        #1;
        chk("pc_out",      pc_out,      m_pc);
        chk("imem_req",    {31'h0, imem_req}, {31'h0, (skid.size() == 0) && !r});
        chk("id_valid",    {31'h0, id_valid}, {31'h0, m_valid});
        chk("id_pc",       id_pc,       m_ipc);
        chk("id_pc_plus4", id_pc_plus4, m_ip4);
        chk("id_instr",    id_instr,    m_instr);
    endtask

    initial begin
        logic        r_r, r_rdy, r_s, r_rv;
        logic [31:0] r_rd, r_rp;

        m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ip4 = 32'h0; m_instr = C_NOP;

        // Reset
        cyc(1, 0, 32'h0, 0, 0, 32'h0);
        cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);

        // Zero-wait streaming
        cyc(0, 1, 32'h2001_0005, 0, 0, 32'h0);
        cyc(0, 1, 32'h2002_0007, 0, 0, 32'h0);
        cyc(0, 1, 32'hAC01_0000, 0, 0, 32'h0);

        // Wait states insert bubbles; rdata ignored while not ready
        cyc(0, 0, 32'hBAD0_0001, 0, 0, 32'h0);
        cyc(0, 0, 32'hBAD0_0002, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_1111, 0, 0, 32'h0);

        // Stall with ready: skid, hold, release
        cyc(0, 1, 32'h1234_5678, 1, 0, 32'h0);
        cyc(0, 1, 32'hBAD0_0003, 1, 0, 32'h0);
        cyc(0, 0, 32'hBAD0_0004, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_2222, 0, 0, 32'h0);

        // Stall over a bubble keeps the bubble
        cyc(0, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 0, 32'h0, 1, 0, 32'h0);
        cyc(0, 1, 32'h0000_3333, 0, 0, 32'h0);

        // Redirect in FETCH (ready word dropped)
        cyc(0, 1, 32'hBAD0_0005, 0, 1, 32'h0000_3100);
        cyc(0, 1, 32'h0000_4444, 0, 0, 32'h0);
        // Redirect in HOLD
        cyc(0, 1, 32'hBAD0_0006, 1, 0, 32'h0);
        cyc(0, 0, 32'h0, 1, 1, 32'h0000_3100);
        cyc(0, 1, 32'h0000_5555, 0, 0, 32'h0);
        // Redirect concurrent with stall
        cyc(0, 1, 32'hBAD0_0007, 1, 1, 32'h0000_3100);
        cyc(0, 1, 32'h0000_6666, 0, 0, 32'h0);

        // Reset during HOLD
        cyc(0, 1, 32'hBAD0_0008, 1, 0, 32'h0);
        cyc(1, 0, 32'h0, 1, 0, 32'h0);
        cyc(0, 1, 32'h0000_7777, 0, 0, 32'h0);

        // PC wrap at top of address space
        cyc(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h0000_8888, 0, 0, 32'h0);
        cyc(0, 1, 32'h0000_9999, 0, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r_r   = ($urandom_range(0, 59) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_s   = ($urandom_range(0, 3) == 0);
            r_rv  = ($urandom_range(0, 11) == 0);
            r_rd  = $urandom;
            r_rp  = {$urandom_range(0, 65535), 2'b00} + 32'h0000_3000;
            cyc(r_r, r_rdy, r_rd, r_s, r_rv, r_rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined CPU: owns the PC register and the IF/ID pipeline register.
- Consumes the incremented PC produced by the next-PC adder (pc+4) and feeds the current PC back to it.
- Drives instruction-memory requests and applies hazard-unit stalls and EX-stage branch/jump redirects.
- Skid-buffers an instruction returned while decode is stalled.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, value loaded into id_instr on reset/flush (MIPS sll $0,$0,0).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
pc_out  output  32  current PC register; drives next-PC adder input and imem address
npc_in  input  32  pc_out+4 from next-PC adder; used unchecked
imem_req  output  1  instruction read request, address = pc_out
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  response for current request; may assert same cycle as imem_req
stall  input  1  hazard unit: hold IF/ID and PC
redirect_valid  input  1  EX-stage taken branch/jump
redirect_pc  input  32  redirect target
id_valid  output  1  IF/ID holds a real instruction
id_pc  output  32  PC of id_instr
id_pc_plus4  output  32  PC+4 of id_instr (link address)
id_instr  output  32  fetched instruction

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - pc_q=RESET_PC, state=FETCH, buffer=0.
  - id_valid=0, id_pc=0, id_pc_plus4=0, id_instr=NOP_INSTR.
  - imem_req=0 during the reset cycle, 1 from the first cycle after.
- rst asserted mid-operation (any state) discards the buffered instruction and overrides every other input.
- pc_out=pc_q combinationally. imem_req=1 in FETCH, 0 in HOLD.
- States: FETCH, HOLD.
- Priority each cycle: rst > redirect_valid > stall > normal.
- FETCH:
  - redirect_valid: pc_q<=redirect_pc; id_valid<=0; id_instr<=NOP_INSTR; any same-cycle imem_ready is dropped; stay FETCH.
  - imem_ready & !stall: id_pc<=pc_q, id_pc_plus4<=npc_in, id_instr<=imem_rdata, id_valid<=1; pc_q<=npc_in.
  - imem_ready & stall: buffer<=imem_rdata; state<=HOLD; PC and IF/ID unchanged.
  - !imem_ready & !stall: id_valid<=0 (bubble), PC unchanged.
  - !imem_ready & stall: everything unchanged.
- HOLD:
  - redirect_valid: pc_q<=redirect_pc; id_valid<=0; id_instr<=NOP_INSTR; buffer discarded; state<=FETCH.
  - !stall: IF/ID <= {pc_q, npc_in, buffer}, id_valid<=1, pc_q<=npc_in, state<=FETCH.
  - stall: everything unchanged.
- Latency and throughput:
  - Zero-wait memory (ready same cycle): one instruction per cycle; IF/ID updates on the edge ending the cycle the address was presented.
  - N wait cycles insert N bubbles.
- Arithmetic:
  - No arithmetic in this block; PC advance is npc_in only.
  - Wrap 32'hFFFF_FFFC->0 is inherited from the adder and accepted.
  - The low two PC bits are not checked.
- Stall with id_valid=0 keeps the bubble (id_valid stays 0).
- Redirect concurrent with stall still flushes IF/ID.
- imem_rdata is ignored whenever imem_ready=0.

Test Plan:
1. Reset, then zero-wait memory returning 32'h2001_0005, 32'h2002_0007, 32'hAC01_0000 -> pc_out 3000,3004,3008,300C on consecutive cycles; id_pc 3000/3004/3008, id_pc_plus4 3004/3008/300C, id_valid=1 from cycle 2.
2. imem_ready low 2 cycles at PC 3004 -> two cycles id_valid=0, pc_out holds 3004; then 3004's instruction appears with id_pc=3004.
3. stall high with imem_ready high at PC 3008 (rdata 32'h1234_5678) -> state HOLD, imem_req=0, IF/ID keeps 3004 entry. Stall low -> id_instr=1234_5678, id_pc=3008, pc_out=300C, no duplicate or lost instruction.
4. redirect_valid with redirect_pc=32'h0000_3100, applied in FETCH, in HOLD, and concurrently with stall -> next cycle pc_out=3100, id_valid=0, id_instr=0, buffered word never reaches ID.
5. rst asserted during HOLD -> next cycle pc_out=3000, id_valid=0, state FETCH, old buffer never emitted.
6. redirect_pc=32'hFFFF_FFFC, then npc_in=0 -> fetch at FFFF_FFFC with id_pc_plus4=0, next pc_out=0.
